id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS32 pipeline, directly downstream of the decode control unit. It registers the decoded control word (RegDst, MemtoReg, ALUOp, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, sign_or_zero) together with operands and register indices for the EX stage. It also detects load-use hazards, inserting a bubble and stalling fetch/decode, and flushes on a taken branch or jump.

## Interface
Parameters:
- DW, 32, datapath width
- CNT_W, 16, width of the stall-event counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_RegDst, id_MemtoReg, id_ALUOp  in  2 each  control word from control unit
- id_Jump, id_Branch, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite, id_sign_or_zero  in  1 each  control word
- id_pc4  in  DW  PC+4 of decode instruction
- id_rs_data, id_rt_data  in  DW  register file read data
- id_imm  in  16  instruction[15:0]
- id_rs, id_rt, id_rd  in  5 each  register indices
- flush  in  1  taken branch/jump resolved; kill decode slot
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_RegDst, ex_MemtoReg, ex_ALUOp  out  2 each  registered control
- ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered control
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DW each  registered operands; ex_imm extended
- ex_rs, ex_rt, ex_rd  out  5 each  registered indices
- stall_count  out  CNT_W  saturating count of hazard bubbles

## Operation
- Extension: ex_imm = sign-extend(id_imm) when id_sign_or_zero=1, else zero-extend. Computed at capture.
- Hazard (macro on): hz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
  - uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch.
- stall = hz & ~flush.
- Priority on each rising edge: reset > flush > stall > load.
- Flush: ex_valid and every ex_ control bit cleared to 0. Data fields still load from id_.
- Stall (bubble): same clearing as flush. stall_count increments and saturates at all-ones.
- Load: all ex_ fields take id_ values, and ex_valid = id_valid.
- When id_valid=0: control bits are loaded as 0 and ex_valid=0, so no memory or register-file side effect occurs.
- Reset value: every output is 0, including stall_count.
- Reset mid-stall: stall drops immediately with reset because ex_valid=0. The first edge after release performs a normal load.

## Timing
- Latency: 1 cycle from id_ inputs to ex_ outputs.
- stall is combinational from registered ex_ state, current id_ indices, and flush. It must be valid before the same edge that captures the bubble.
- A load-use pair costs exactly 1 bubble. On the next cycle the load has left EX, so hz=0 and the dependent instruction is captured.
- flush and hz in the same cycle: flush wins, stall=0, the bubble is not counted, and stall_count is unchanged.
- Back-to-back hazards each count separately.

## Configuration
- ID_EX_HAZARD_EN defined: hazard detection, stall output, and stall_count are active as described.
- ID_EX_HAZARD_EN undefined:
  - stall tied to 0 and stall_count tied to 0; no counter flops.
  - Load-use ordering is the compiler's responsibility, via a nop after each lw.
  - Flush and load behaviour are unchanged.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010, OP_JAL 6'b000011, OP_ADDI 6'b001000
  - ALUOp encodings 00/01/10/11
  - a ctrl_word typedef bundling the ten control fields
  - BUBBLE_CTRL constant (all zero)
- One sub-module, hazard_detect: a purely combinational hz computation, instantiated only under ID_EX_HAZARD_EN. The counter stays in id_ex_stage.

## Test plan
- Reset: assert reset=0 mid-traffic -> all ex_ outputs 0 and stall_count 0, asynchronously, before the next clk edge.
- Extension:
  - addi, id_imm=16'hFFF0, sign_or_zero=1 -> ex_imm=32'hFFFFFFF0 one cycle later
  - beq, id_imm=16'hFFF0, sign_or_zero=0 -> ex_imm=32'h0000FFF0
- Load-use: lw with rt=5 in EX, then add with rs=5 in ID -> stall=1 for one cycle, one bubble (ex_valid=0, ex_RegWrite=0), stall_count=1; the add reaches EX the following cycle.
- No false hazard:
  - lw with rt=0, then add with rs=0 -> stall=0
  - lw with rt=5, then addi with rt=5 and rs=3 -> stall=0, since rt is not a source
- Flush priority: hazard condition present and flush=1 -> stall=0, ex_valid=0, all ex_ control 0, stall_count unchanged.
- Saturation: with CNT_W=4, force 17 hazard bubbles -> stall_count holds 4'hF. With the macro undefined, the same stimulus gives stall=0 throughout and the add enters EX immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, ALUOp encodings and control-word types
// used by the decode and ID/EX stages.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       sign_or_zero;
    } ctrl_word;

    // sign_or_zero is consumed at capture, so the EX copy drops it
    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ex_ctrl_t;

    localparam ctrl_word BUBBLE_CTRL = '0;

    function automatic ex_ctrl_t to_ex_ctrl(input ctrl_word c);
        ex_ctrl_t e;
        e.reg_dst    = c.reg_dst;
        e.mem_to_reg = c.mem_to_reg;
        e.alu_op     = c.alu_op;
        e.jump       = c.jump;
        e.branch     = c.branch;
        e.mem_read   = c.mem_read;
        e.mem_write  = c.mem_write;
        e.alu_src    = c.alu_src;
        e.reg_write  = c.reg_write;
        return e;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register
// being loaded by the lw currently in EX.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    input  logic       id_branch,
    output logic       hz
);

    logic uses_rt;

    // rt is a source for R-type, store data and branch compare, but not for addi/lw
    assign uses_rt = ~id_alu_src | id_mem_write | id_branch;

    assign hz = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid &
                ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush and optional load-use bubble insertion.
// Define ID_EX_HAZARD_EN to enable hazard detection, stall and stall_count.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_RegDst,
    input  logic [1:0]       id_MemtoReg,
    input  logic [1:0]       id_ALUOp,
    input  logic             id_Jump,
    input  logic             id_Branch,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_RegWrite,
    input  logic             id_sign_or_zero,
    input  logic [DW-1:0]    id_pc4,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       ex_RegDst,
    output logic [1:0]       ex_MemtoReg,
    output logic [1:0]       ex_ALUOp,
    output logic             ex_Jump,
    output logic             ex_Branch,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [DW-1:0]    ex_pc4,
    output logic [DW-1:0]    ex_rs_data,
    output logic [DW-1:0]    ex_rt_data,
    output logic [DW-1:0]    ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_word      id_ctrl;
    ex_ctrl_t      ctrl_d, ctrl_q;
    logic          valid_d, valid_q;
    logic [DW-1:0] pc4_d, pc4_q, rs_data_d, rs_data_q, rt_data_d, rt_data_q, imm_d, imm_q;
    logic [4:0]    rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic          kill;

    always_comb begin
        id_ctrl              = BUBBLE_CTRL;
        id_ctrl.reg_dst      = id_RegDst;
        id_ctrl.mem_to_reg   = id_MemtoReg;
        id_ctrl.alu_op       = id_ALUOp;
        id_ctrl.jump         = id_Jump;
        id_ctrl.branch       = id_Branch;
        id_ctrl.mem_read     = id_MemRead;
        id_ctrl.mem_write    = id_MemWrite;
        id_ctrl.alu_src      = id_ALUSrc;
        id_ctrl.reg_write    = id_RegWrite;
        id_ctrl.sign_or_zero = id_sign_or_zero;
    end

`ifdef ID_EX_HAZARD_EN
    logic             hz;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    hazard_detect u_hazard_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_alu_src  (id_ALUSrc),
        .id_mem_write(id_MemWrite),
        .id_branch   (id_Branch),
        .hz          (hz)
    );

    // flush overrides the hazard, so a killed slot is never counted as a bubble
    assign stall = hz & ~flush;
    assign kill  = flush | stall;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall       = 1'b0;
    assign kill        = flush;
    assign stall_count = '0;
`endif

    // Data fields always follow decode; only control and valid are squashed
    always_comb begin
        valid_d   = id_valid;
        ctrl_d    = to_ex_ctrl(id_ctrl);
        if (!id_valid || kill) begin
            valid_d = 1'b0;
            ctrl_d  = to_ex_ctrl(BUBBLE_CTRL);
        end
        pc4_d     = id_pc4;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_sign_or_zero ? {{(DW-16){id_imm[15]}}, id_imm}
                                    : {{(DW-16){1'b0}}, id_imm};
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegDst   = ctrl_q.reg_dst;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_Jump     = ctrl_q.jump;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_pc4      = pc4_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow ID_EX_HAZARD_EN
// the same way the DUT build does.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [1:0]       id_RegDst, id_MemtoReg, id_ALUOp;
    logic             id_Jump, id_Branch, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite, id_sign_or_zero;
    logic [DW-1:0]    id_pc4, id_rs_data, id_rt_data;
    logic [15:0]      id_imm;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [1:0]       ex_RegDst, ex_MemtoReg, ex_ALUOp;
    logic             ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [DW-1:0]    ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic [CNT_W-1:0] stall_count;

    typedef struct packed {
        logic        valid;
        logic [1:0]  reg_dst, mem_to_reg, alu_op;
        logic        jump, branch, mem_read, mem_write, alu_src, reg_write;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } ex_state_t;

    typedef struct packed {
        ex_state_t  st;
        logic [3:0] cnt;
    } sb_t;

    sb_t        exp_q[$];
    ex_state_t  model;
    logic [3:0] model_cnt;
    ex_state_t  act;
    logic       last_stall;
    int         total = 0;
    int         bad = 0;

    assign act = {ex_valid, ex_RegDst, ex_MemtoReg, ex_ALUOp, ex_Jump, ex_Branch, ex_MemRead,
                  ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                  ex_rs, ex_rt, ex_rd};

    id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
        .id_Jump(id_Jump), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_sign_or_zero(id_sign_or_zero), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg), .ex_ALUOp(ex_ALUOp),
        .ex_Jump(ex_Jump), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decoder table for the opcodes the bench uses
    task automatic driveInputs(input logic [5:0] op, input logic valid, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                               input logic sgn, input logic fl);
        id_valid = valid; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
        id_sign_or_zero = sgn; flush = fl;
        id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_RegDst = 2'd0; id_MemtoReg = 2'd0; id_ALUOp = 2'd0;
        id_Jump = 0; id_Branch = 0; id_MemRead = 0; id_MemWrite = 0; id_ALUSrc = 0; id_RegWrite = 0;
        case (op)
            OP_RTYPE: begin id_RegDst = 2'd1; id_ALUOp = 2'b10; id_RegWrite = 1; end
            OP_LW:    begin id_MemtoReg = 2'd1; id_MemRead = 1; id_ALUSrc = 1; id_RegWrite = 1; end
            OP_SW:    begin id_ALUSrc = 1; id_MemWrite = 1; end
            OP_BEQ:   begin id_Branch = 1; id_ALUOp = 2'b01; end
            OP_J:     begin id_Jump = 1; end
            OP_JAL:   begin id_Jump = 1; id_RegDst = 2'd2; id_MemtoReg = 2'd2; id_RegWrite = 1; end
            OP_ADDI:  begin id_ALUSrc = 1; id_RegWrite = 1; end
            default:  ;
        endcase
    endtask

    // Drive one decode slot, check stall before the edge, check EX after it
    task automatic applyStimulus(input logic [5:0] op, input logic valid, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                                 input logic sgn, input logic fl);
        logic      hz, exp_stall, uses_rt;
        ex_state_t nxt;
        sb_t       got;
        driveInputs(op, valid, rs, rt, rd, imm, sgn, fl);
        #2;
        uses_rt = !id_ALUSrc || id_MemWrite || id_Branch;
        hz = 1'b0;
`ifdef ID_EX_HAZARD_EN
        hz = model.valid && model.mem_read && (model.rt != 5'd0) && valid &&
             ((model.rt == rs) || (uses_rt && (model.rt == rt)));
`endif
        exp_stall = hz && !fl;
        checkOutput("stall", {255'd0, stall}, {255'd0, exp_stall});
        nxt = '0;
        if (valid && !fl && !exp_stall) begin
            nxt.valid = 1'b1;
            nxt.reg_dst = id_RegDst; nxt.mem_to_reg = id_MemtoReg; nxt.alu_op = id_ALUOp;
            nxt.jump = id_Jump; nxt.branch = id_Branch; nxt.mem_read = id_MemRead;
            nxt.mem_write = id_MemWrite; nxt.alu_src = id_ALUSrc; nxt.reg_write = id_RegWrite;
        end
        nxt.pc4 = id_pc4; nxt.rs_data = id_rs_data; nxt.rt_data = id_rt_data;
        nxt.imm = sgn ? {{16{imm[15]}}, imm} : {16'h0000, imm};
        nxt.rs = rs; nxt.rt = rt; nxt.rd = rd;
        if (exp_stall && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        exp_q.push_back('{st: nxt, cnt: model_cnt});
        last_stall = exp_stall;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 256'd0, 256'd1);
        end else begin
            got = exp_q.pop_front();
            checkOutput("ex_state", {100'd0, act}, {100'd0, got.st});
            checkOutput("stall_count", {252'd0, stall_count}, {252'd0, got.cnt});
            model = got.st;
        end
        @(negedge clk);
    endtask

    initial begin
        model = '0; model_cnt = 4'd0; last_stall = 1'b0;
        reset = 1'b0;
        driveInputs(OP_RTYPE, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_outputs", {100'd0, act}, 256'd0);
        checkOutput("reset_count", {252'd0, stall_count}, 256'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        applyStimulus(OP_ADDI, 1, 5'd1, 5'd2, 5'd0, 16'hFFF0, 1, 0);
        checkOutput("imm_sext", {224'd0, ex_imm}, {224'd0, 32'hFFFFFFF0});
        applyStimulus(OP_BEQ, 1, 5'd1, 5'd2, 5'd0, 16'hFFF0, 0, 0);
        checkOutput("imm_zext", {224'd0, ex_imm}, {224'd0, 32'h0000FFF0});

        applyStimulus(OP_LW, 1, 5'd1, 5'd5, 5'd0, 16'h0004, 1, 0);
        applyStimulus(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);
        if (last_stall) applyStimulus(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);
`ifdef ID_EX_HAZARD_EN
        checkOutput("loaduse_count", {252'd0, stall_count}, {252'd0, 4'd1});
`else
        checkOutput("loaduse_count", {252'd0, stall_count}, 256'd0);
`endif
        checkOutput("loaduse_add_in_ex", {251'd0, ex_valid, ex_rs}, {251'd0, 1'b1, 5'd5});

        applyStimulus(OP_LW, 1, 5'd1, 5'd0, 5'd0, 16'h0, 1, 0);
        applyStimulus(OP_RTYPE, 1, 5'd0, 5'd6, 5'd7, 16'h0, 0, 0);
        applyStimulus(OP_LW, 1, 5'd1, 5'd5, 5'd0, 16'h0, 1, 0);
        applyStimulus(OP_ADDI, 1, 5'd3, 5'd5, 5'd0, 16'h0010, 1, 0);

        applyStimulus(OP_LW, 1, 5'd1, 5'd9, 5'd0, 16'h0, 1, 0);
        applyStimulus(OP_SW, 1, 5'd2, 5'd9, 5'd0, 16'h0008, 1, 0);
        if (last_stall) applyStimulus(OP_SW, 1, 5'd2, 5'd9, 5'd0, 16'h0008, 1, 0);

        applyStimulus(OP_LW, 1, 5'd1, 5'd8, 5'd0, 16'h0, 1, 0);
        applyStimulus(OP_RTYPE, 1, 5'd8, 5'd8, 5'd4, 16'h0, 0, 1);
        applyStimulus(OP_LW, 0, 5'd1, 5'd3, 5'd0, 16'h0, 1, 0);
        applyStimulus(OP_J, 1, 5'd0, 5'd0, 5'd0, 16'h1234, 0, 0);
        applyStimulus(OP_JAL, 1, 5'd0, 5'd0, 5'd31, 16'h8000, 0, 0);

        // Asynchronous reset while a load-use stall is being asserted
        applyStimulus(OP_LW, 1, 5'd1, 5'd5, 5'd0, 16'h0, 1, 0);
        driveInputs(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_stall", {255'd0, stall}, 256'd0);
        checkOutput("reset_mid_outputs", {100'd0, act}, 256'd0);
        checkOutput("reset_mid_count", {252'd0, stall_count}, 256'd0);
        model = '0; model_cnt = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(OP_LW, 1, 5'd1, 5'd5, 5'd0, 16'h0, 1, 0);
            applyStimulus(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);
            if (last_stall) applyStimulus(OP_RTYPE, 1, 5'd5, 5'd6, 5'd7, 16'h0, 0, 0);
        end
`ifdef ID_EX_HAZARD_EN
        checkOutput("saturated_count", {252'd0, stall_count}, {252'd0, 4'hF});
`else
        checkOutput("saturated_count", {252'd0, stall_count}, 256'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
